// File: rtl/pwm_ctrl_pkg.sv
// Shared types, widths and the ramp-step helper for the PWM soft-start slice.
//   state_t      : controller state encoding (IDLE, RAMP, KILL)
//   PWM_PERIOD_W : width of the PWM period counter (1024 clk per period)
//   DUTY_W       : width of the duty command and target
//   ramp_next()  : one slew step of cmd toward target, clamped at target
package pwm_ctrl_pkg;

    localparam int unsigned PWM_PERIOD_W = 10;
    localparam int unsigned DUTY_W       = 8;
    localparam int unsigned DUTY_EXT_W   = DUTY_W + 1;
    localparam int unsigned DIV_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        KILL = 2'd2
    } state_t;

    // One step toward tgt. Work in 9 bits so cur + s cannot wrap, and land
    // exactly on tgt when the remaining distance is within one step.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] stp
    );
        logic [DUTY_EXT_W-1:0] s;
        logic [DUTY_EXT_W-1:0] d;
        logic [DUTY_EXT_W-1:0] r;
        s = (stp == '0) ? DUTY_EXT_W'(1) : {1'b0, stp};
        if (tgt >= cur) begin
            d = {1'b0, tgt} - {1'b0, cur};
            r = (d <= s) ? {1'b0, tgt} : ({1'b0, cur} + s);
        end else begin
            d = {1'b0, cur} - {1'b0, tgt};
            r = (d <= s) ? {1'b0, tgt} : ({1'b0, cur} - s);
        end
        return r[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period and ramp-divider timebase.
//   clk, rst     : clock, synchronous active-high reset
//   period_start : one-cycle strobe while pcnt == 2**PERIOD_W-1
//   step_tick    : period_start on the DIV_PERIODS-th boundary
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD_W    = PWM_PERIOD_W,
    parameter int unsigned DIV_PERIODS = 1
) (
    input  logic clk,
    input  logic rst,
    output logic period_start,
    output logic step_tick
);

    localparam logic [PERIOD_W-1:0] PCNT_LAST = '1;
    localparam logic [PERIOD_W-1:0] PCNT_PRE  = PCNT_LAST - PERIOD_W'(1);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(DIV_PERIODS - 1);

    logic [PERIOD_W-1:0] pcnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                boundary_c;
    logic                pre_boundary_c;

    assign boundary_c     = (pcnt == PCNT_LAST);
    assign pre_boundary_c = (pcnt == PCNT_PRE);

    // Free-running period counter; aligned with the PWM generator at reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PERIOD_W'(1);
        end
    end

    // Counts boundaries 0..DIV_PERIODS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (boundary_c) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Strobes are registered one count early so they sit exactly on pcnt == last.
    // div_cnt only moves on a boundary, so its value one cycle early is the same.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start <= 1'b0;
            step_tick    <= 1'b0;
        end else begin
            period_start <= pre_boundary_c;
            step_tick    <= pre_boundary_c && (div_cnt == DIV_LAST);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / slew-rate controller for the PWM duty command.
//   clk, rst       : clock, synchronous active-high reset
//   tgt_valid/tgt_duty/tgt_ready : target duty handshake
//   step           : ramp increment per step tick (0 behaves as 1)
//   fault          : level kill request, forces cmd to 0 next cycle
//   clr_fault      : pulse that leaves KILL once fault is low
//   cmd            : duty command, changes only at period boundaries (or on kill)
//   busy           : state is RAMP
//   at_target      : cmd == target outside KILL
//   fault_latched  : state is KILL
//   period_start   : strobe on the last count of each PWM period
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD_W    = PWM_PERIOD_W,
    parameter int unsigned DIV_PERIODS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    input  logic [DUTY_W-1:0] step,
    input  logic              fault,
    input  logic              clr_fault,
    output logic [DUTY_W-1:0] cmd,
    output logic              busy,
    output logic              at_target,
    output logic              fault_latched,
    output logic              period_start
);

    state_t            state;
    state_t            state_n;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] target_n;
    logic [DUTY_W-1:0] cmd_n;
    logic              step_tick;
    logic              accept_c;

    pwm_period_timer #(
        .PERIOD_W    (PERIOD_W),
        .DIV_PERIODS (DIV_PERIODS)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .period_start (period_start),
        .step_tick    (step_tick)
    );

    assign accept_c = tgt_valid && (state != KILL);

    // State, datapath and status registers; status flags track the next state
    // so they stay registered while matching the decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd           <= '0;
            target        <= '0;
            tgt_ready     <= 1'b1;
            busy          <= 1'b0;
            at_target     <= 1'b1;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_n;
            cmd           <= cmd_n;
            target        <= target_n;
            tgt_ready     <= (state_n != KILL);
            busy          <= (state_n == RAMP);
            at_target     <= (state_n != KILL) && (cmd_n == target_n);
            fault_latched <= (state_n == KILL);
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_n  = state;
        cmd_n    = cmd;
        target_n = target;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    target_n = tgt_duty;
                    state_n  = (tgt_duty == cmd) ? IDLE : RAMP;
                end
            end
            RAMP: begin
                // A tick in the acceptance cycle still steps toward the old target.
                if (step_tick) begin
                    cmd_n = ramp_next(cmd, target, step);
                    if (cmd_n == target) begin
                        state_n = IDLE;
                    end
                end
                if (accept_c) begin
                    target_n = tgt_duty;
                    state_n  = (tgt_duty == cmd_n) ? IDLE : RAMP;
                end
            end
            KILL: begin
                if (clr_fault) begin
                    state_n  = IDLE;
                    cmd_n    = '0;
                    target_n = '0;
                end
            end
            default: begin
                state_n  = IDLE;
                cmd_n    = '0;
                target_n = '0;
            end
        endcase

        // Kill overrides everything except reset, and is not period-aligned.
        if (fault) begin
            state_n  = KILL;
            cmd_n    = '0;
            target_n = '0;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramp vectors plus
// hand-written sequences for kill, retarget, coincident tick and reset.
module tb_pwm_ramp_ctrl;

    localparam int unsigned PW = 10;
    localparam int unsigned LAST = 1023;

    typedef struct packed {
        logic [7:0]      tgt;
        logic [7:0]      stp;
        logic [2:0]      n;
        logic [3:0][7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic [7:0] tgt_duty;
    logic       tgt_ready;
    logic [7:0] step;
    logic       fault;
    logic       clr_fault;
    logic [7:0] cmd;
    logic       busy;
    logic       at_target;
    logic       fault_latched;
    logic       period_start;

    int errors = 0;
    int checks = 0;

    // Bench copy of the period counter: pcnt after k post-reset edges is k mod 1024.
    logic [31:0]   k;
    logic [PW-1:0] pcnt_m;
    assign pcnt_m = k[PW-1:0];

    always @(posedge clk) begin
        if (rst) k <= '0;
        else     k <= k + 32'd1;
    end

    pwm_ramp_ctrl #(
        .PERIOD_W    (PW),
        .DIV_PERIODS (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tgt_valid     (tgt_valid),
        .tgt_duty      (tgt_duty),
        .tgt_ready     (tgt_ready),
        .step          (step),
        .fault         (fault),
        .clr_fault     (clr_fault),
        .cmd           (cmd),
        .busy          (busy),
        .at_target     (at_target),
        .fault_latched (fault_latched),
        .period_start  (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (pcnt=%0d)", name, act, exp, pcnt_m);
        end
    endtask

    // Advance to the next negedge where the modelled pcnt equals v.
    task automatic wait_pcnt(input int v);
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (int'(pcnt_m) == v) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pcnt: timeout waiting for pcnt=%0d", v);
    endtask

    // One-cycle target offer, returns at the negedge after the accepting edge.
    task automatic offer(input logic [7:0] t);
        tgt_valid = 1'b1;
        tgt_duty  = t;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] t, input logic [7:0] s, input logic [2:0] n,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.tgt = t;
        v.stp = s;
        v.n   = n;
        v.exp = {8'd0, e2, e1, e0};
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int cur;
        int pulses;
        int mism;

        vecs[0] = mk(8'd40,  8'd16,  3'd3, 8'd16,  8'd32,  8'd40);
        vecs[1] = mk(8'd0,   8'd16,  3'd3, 8'd24,  8'd8,   8'd0);
        vecs[2] = mk(8'd250, 8'd255, 3'd1, 8'd250, 8'd0,   8'd0);
        vecs[3] = mk(8'd255, 8'd16,  3'd1, 8'd255, 8'd0,   8'd0);
        vecs[4] = mk(8'd252, 8'd0,   3'd3, 8'd254, 8'd253, 8'd252);
        vecs[5] = mk(8'd0,   8'd200, 3'd2, 8'd52,  8'd0,   8'd0);
        vecs[6] = mk(8'd3,   8'd0,   3'd3, 8'd1,   8'd2,   8'd3);
        vecs[7] = mk(8'd0,   8'd0,   3'd3, 8'd2,   8'd1,   8'd0);

        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_duty  = '0;
        step      = '0;
        fault     = 1'b0;
        clr_fault = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_cmd", int'(cmd), 0);
        chk("rst_tgt_ready", int'(tgt_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_fault_latched", int'(fault_latched), 0);
        chk("rst_period_start", int'(period_start), 0);
        rst = 1'b0;

        // Idle for two periods: strobe must sit exactly on pcnt == 1023.
        pulses = 0;
        mism   = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (period_start) pulses++;
            if (period_start !== (int'(pcnt_m) == LAST)) mism++;
        end
        chk("idle_period_pulses", pulses, 2);
        chk("idle_period_align", mism, 0);
        chk("idle_cmd", int'(cmd), 0);
        chk("idle_at_target", int'(at_target), 1);
        chk("idle_tgt_ready", int'(tgt_ready), 1);

        // Table-driven ramps.
        cur = 0;
        for (int v = 0; v < 8; v++) begin
            wait_pcnt(100);
            step = vecs[v].stp;
            offer(vecs[v].tgt);
            chk($sformatf("v%0d_busy_after_accept", v), int'(busy), 1);
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                wait_pcnt(512);
                chk($sformatf("v%0d_s%0d_midperiod_cmd", v, j), int'(cmd), cur);
                wait_pcnt(0);
                chk($sformatf("v%0d_s%0d_cmd", v, j), int'(cmd), int'(vecs[v].exp[j]));
                cur = int'(vecs[v].exp[j]);
                chk($sformatf("v%0d_s%0d_busy", v, j), int'(busy), int'(j < int'(vecs[v].n) - 1));
            end
            chk($sformatf("v%0d_at_target", v), int'(at_target), 1);
        end

        // Fault mid-ramp at cmd = 32.
        step = 8'd16;
        wait_pcnt(100);
        offer(8'd64);
        wait_pcnt(0);
        chk("flt_ramp_cmd16", int'(cmd), 16);
        wait_pcnt(0);
        chk("flt_ramp_cmd32", int'(cmd), 32);
        wait_pcnt(10);
        fault = 1'b1;
        @(negedge clk);
        chk("flt_cmd", int'(cmd), 0);
        chk("flt_tgt_ready", int'(tgt_ready), 0);
        chk("flt_latched", int'(fault_latched), 1);
        chk("flt_busy", int'(busy), 0);
        chk("flt_at_target", int'(at_target), 0);
        offer(8'd100);
        chk("flt_ignore_valid", int'(fault_latched), 1);
        wait_pcnt(LAST);
        chk("flt_period_start", int'(period_start), 1);
        wait_pcnt(0);
        chk("flt_cmd_hold", int'(cmd), 0);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        chk("flt_clr_while_fault", int'(fault_latched), 1);
        fault = 1'b0;
        @(negedge clk);
        chk("flt_drop_no_clr", int'(fault_latched), 1);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        chk("flt_exit_latched", int'(fault_latched), 0);
        chk("flt_exit_cmd", int'(cmd), 0);
        chk("flt_exit_tgt_ready", int'(tgt_ready), 1);
        chk("flt_exit_at_target", int'(at_target), 1);
        chk("flt_exit_busy", int'(busy), 0);
        wait_pcnt(0);
        chk("flt_exit_cmd_period", int'(cmd), 0);

        // Retarget 200 -> 10 at cmd = 64, step 32.
        step = 8'd32;
        wait_pcnt(100);
        offer(8'd200);
        wait_pcnt(0);
        chk("rt_cmd32", int'(cmd), 32);
        wait_pcnt(0);
        chk("rt_cmd64", int'(cmd), 64);
        wait_pcnt(100);
        offer(8'd10);
        chk("rt_busy", int'(busy), 1);
        wait_pcnt(0);
        chk("rt_down32", int'(cmd), 32);
        wait_pcnt(0);
        chk("rt_down10", int'(cmd), 10);
        chk("rt_done_busy", int'(busy), 0);
        chk("rt_done_at_target", int'(at_target), 1);

        // Retarget to the current cmd during RAMP returns to IDLE.
        step = 8'd8;
        wait_pcnt(100);
        offer(8'd100);
        wait_pcnt(0);
        chk("eq_cmd18", int'(cmd), 18);
        wait_pcnt(100);
        offer(8'd18);
        chk("eq_busy", int'(busy), 0);
        chk("eq_at_target", int'(at_target), 1);
        wait_pcnt(0);
        chk("eq_cmd_hold", int'(cmd), 18);

        // Acceptance on the tick cycle: tick uses the old target (50).
        step = 8'd10;
        wait_pcnt(100);
        offer(8'd50);
        wait_pcnt(0);
        chk("co_cmd28", int'(cmd), 28);
        wait_pcnt(LAST);
        offer(8'd0);
        chk("co_tick_old_target", int'(cmd), 38);
        chk("co_busy", int'(busy), 1);
        wait_pcnt(0);
        chk("co_new_target_28", int'(cmd), 28);
        wait_pcnt(0);
        chk("co_new_target_18", int'(cmd), 18);

        // Reset mid-ramp.
        wait_pcnt(100);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cmd", int'(cmd), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_at_target", int'(at_target), 1);
        chk("mrst_tgt_ready", int'(tgt_ready), 1);
        chk("mrst_period_start", int'(period_start), 0);
        rst = 1'b0;
        wait_pcnt(0);
        chk("mrst_cmd_after_period", int'(cmd), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Soft-start / slew-rate controller that sequences the 8-bit duty command `cmd` feeding the PWM generator.
- The generator has a free-running 10-bit counter: 1024 clk per PWM period.
- This block accepts a target duty over a valid/ready handshake, ramps its `cmd` output toward the target by a programmable step every DIV_PERIODS PWM periods, and changes `cmd` only at period boundaries.
- A fault input forces `cmd` to 0 immediately and latches until cleared by software.

Parameters:
- PERIOD_W, 10: width of the internal period counter. Period = 2**PERIOD_W clk; must match the PWM counter width.
- DIV_PERIODS, 1: number of PWM periods between ramp steps. Legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tgt_valid  input  1  new target duty offered
- tgt_duty  input  8  target duty, 0..255
- tgt_ready  output  1  target accepted when tgt_valid && tgt_ready
- step  input  8  ramp increment per step; value 0 is treated as 1
- fault  input  1  level-sensitive kill request
- clr_fault  input  1  single-cycle pulse that clears the latched fault
- cmd  output  8  registered duty command to the PWM generator
- busy  output  1  high while state is RAMP
- at_target  output  1  high when cmd == target and state is not KILL
- fault_latched  output  1  high while state is KILL
- period_start  output  1  one-cycle strobe on the cycle where pcnt == 2**PERIOD_W-1

Behaviour:
- Reset values: cmd = 0, target = 0, pcnt = 0, div_cnt = 0, state = IDLE. Outputs after reset: tgt_ready = 1, busy = 0, at_target = 1, fault_latched = 0, period_start = 0.
- pcnt is a PERIOD_W-bit free-running counter that wraps 1023 -> 0. Releasing rst in the same cycle as the PWM generator keeps the two counters aligned.
- Boundary: a cycle with pcnt == 1023. div_cnt counts boundaries 0..DIV_PERIODS-1. A step tick is a boundary where div_cnt == DIV_PERIODS-1; div_cnt returns to 0 on that tick.
- tgt_ready = (state != KILL), combinational from state. On acceptance, target <= tgt_duty on the next edge.
- State IDLE:
  - Accepting a target != cmd moves to RAMP next cycle.
  - Accepting a target == cmd stays in IDLE.
- State RAMP, on each step tick:
  - Let d = |target - cmd| and s = max(step, 1).
  - If d <= s: cmd <= target and state -> IDLE.
  - Otherwise: cmd <= cmd ± s toward target.
  - Arithmetic is 9-bit internally. cmd never wraps and never overshoots the target.
- Latency: cmd updates only on the edge that ends a step-tick cycle, so a new value is visible at pcnt == 0. The first step after acceptance occurs at the next step tick; there is no immediate step.
- Retarget during RAMP is allowed. A step tick in the same cycle as acceptance uses the old target; the new target is used from the next tick on. If the new target equals cmd, state -> IDLE next cycle.
- KILL entry: fault == 1 in any state → next cycle cmd = 0, state = KILL, target = 0. This is not period-aligned. Priority order is rst > fault > step/handshake.
- KILL exit: clr_fault && !fault → IDLE with cmd = 0. clr_fault while fault == 1 is ignored.
- busy = (state == RAMP). at_target = (state != KILL) && (cmd == target).
- Reset mid-ramp returns all state to reset values on the next edge.
- period_start is independent of state. It continues in KILL.

Decomposition:
- Package pwm_ctrl_pkg contains:
  - state enum {IDLE, RAMP, KILL}, 2 bits;
  - localparam PWM_PERIOD_W = 10;
  - DUTY_W = 8.
- Sub-module pwm_period_timer holds pcnt and div_cnt. It outputs period_start and step_tick.
- The top level holds the FSM, target/cmd registers and the step arithmetic.

Test Plan:
- Reset, then run 2048 cycles idle → cmd = 0, at_target = 1, tgt_ready = 1, period_start pulses every 1024 clk.
- Offer target 40 with step 16 (DIV_PERIODS = 1) → cmd reads 16, 32, 40 at successive period starts (pcnt == 0), busy drops with the 40 update, at_target = 1; cmd never changes mid-period.
- From cmd = 40, offer target 0 with step 16 → cmd 24, 8, 0 at successive boundaries, no underflow.
- cmd = 250, target 255, step 16 → cmd = 255 at the next boundary, no wrap. With step = 0 and target 3 from 0 → 1, 2, 3.
- Raise fault mid-ramp at cmd = 32 → cmd = 0 on the next cycle, tgt_ready = 0, fault_latched = 1, tgt_valid ignored. clr_fault while fault = 1 → remains in KILL. Drop fault, then pulse clr_fault → IDLE, cmd = 0.
- Retarget 200 → 10 while at cmd = 64 with step 32 → next ticks give 32, then 10. Assert rst mid-ramp → cmd = 0 on the next edge.
